// File: rtl/seg7_scan_display_if.sv
// Status bus from the elevator controller into the display stage, and the
// multiplexed seven-segment drive coming back out of it.
`timescale 1us/1ns
interface seg7_scan_display_if;
    logic [15:0] data_bus;    // [15:12] state, [11:8] floor, [7:4] direction, [3:0] door
    logic        blink_en;    // blink floor digit while the door nibble is 0
    logic        lamp_test;   // light every segment and dp on scanned digits
    logic [6:0]  seg_n;       // {g,f,e,d,c,b,a}, active-low
    logic        dp_n;        // decimal point, active-low
    logic [3:0]  an_n;        // digit anodes, active-low, an_n[3] = leftmost
    logic        frame_tick;  // one-cycle pulse at the start of each frame

    // Controller / bench side: drives status, observes the display drive.
    modport master (
        output data_bus, blink_en, lamp_test,
        input  seg_n, dp_n, an_n, frame_tick
    );

    // Display side.
    modport slave (
        input  data_bus, blink_en, lamp_test,
        output seg_n, dp_n, an_n, frame_tick
    );
endinterface

// File: rtl/seg7_scan_display.sv
// Four-digit common-anode scan driver for the elevator status bus.
// A snapshot of the bus is taken once per frame so a digit never tears
// mid-frame; each digit slot opens with one blanked cycle against ghosting.
`timescale 1us/1ns
module seg7_scan_display #(
    parameter int SCAN_DIV  = 25,    // clk cycles per digit slot (>= 2)
    parameter int BLINK_DIV = 2500   // clk cycles per blink half-period (>= 1)
) (
    input  logic               clk10000hz,
    input  logic               reset,
    seg7_scan_display_if.slave bus
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [SW-1:0] r_scan_cnt;
    logic [1:0]    r_digit;
    logic [15:0]   r_shadow;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;

    logic          w_frame_start;
    logic          w_dead;
    logic          w_blink_blank;
    logic [3:0]    w_nibble;
    logic [6:0]    w_glyph;

    // Frame boundary, dead-time slot and floor-digit blink condition.
    assign w_frame_start = ~reset && (r_digit == 2'd3) && (r_scan_cnt == '0);
    assign w_dead        = (r_scan_cnt == '0);
    assign w_nibble      = r_shadow[{r_digit, 2'b00} +: 4];
    assign w_blink_blank = bus.blink_en && (r_shadow[3:0] == 4'h0) &&
                           r_phase && (r_digit == 2'd2);

    // Scan timing, per-frame snapshot and free-running blink phase.
    always_ff @(posedge clk10000hz) begin
        // NOTE: non-blocking so every register sees pre-edge values of the others.
        if (reset) begin
            r_scan_cnt  <= '0;
            r_digit     <= 2'd3;
            r_shadow    <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_digit    <= r_digit - 2'd1;   // 0 wraps back to 3
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end

            if (w_frame_start) begin
                r_shadow <= bus.data_bus;
            end

            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Elevator glyph set: digits, 'U' up, 'd' down, '-' wait, 'E' fault, blank.
    always_comb begin
        // NOTE: default first so every path assigns w_glyph and no latch is inferred.
        w_glyph = 7'b1111111;
        case (w_nibble)
            4'd0:  w_glyph = 7'b1000000;
            4'd1:  w_glyph = 7'b1111001;
            4'd2:  w_glyph = 7'b0100100;
            4'd3:  w_glyph = 7'b0110000;
            4'd4:  w_glyph = 7'b0011001;
            4'd5:  w_glyph = 7'b0010010;
            4'd6:  w_glyph = 7'b0000010;
            4'd7:  w_glyph = 7'b1111000;
            4'd8:  w_glyph = 7'b0000000;
            4'd9:  w_glyph = 7'b0010000;
            4'd10: w_glyph = 7'b1000001;
            4'd11: w_glyph = 7'b0100001;
            4'd12: w_glyph = 7'b0111111;
            4'd13: w_glyph = 7'b0000110;
            4'd14: w_glyph = 7'b0000110;
            default: w_glyph = 7'b1111111;
        endcase
    end

    // Output drive: idle under reset, dark in dead time, lamp test over glyphs.
    always_comb begin
        bus.an_n       = 4'b1111;
        bus.seg_n      = 7'b1111111;
        bus.dp_n       = 1'b1;
        bus.frame_tick = 1'b0;
        if (!reset) begin
            bus.frame_tick = w_frame_start;
            if (!w_dead) begin
                bus.an_n = ~(4'b0001 << r_digit);
                if (bus.lamp_test) begin
                    bus.seg_n = 7'b0000000;
                    bus.dp_n  = 1'b0;
                end else if (w_blink_blank) begin
                    bus.seg_n = 7'b1111111;
                end else begin
                    bus.seg_n = w_glyph;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display at default parameters: each frame's
// expected digits are queued when its status word is driven and popped as the
// display scans them out.
`timescale 1us/1ns
module tb_seg7_scan_display;
    logic clk10000hz = 1'b0;
    logic reset      = 1'b1;

    seg7_scan_display_if bus();

    seg7_scan_display #(.SCAN_DIV(25), .BLINK_DIV(2500)) dut (
        .clk10000hz (clk10000hz),
        .reset      (reset),
        .bus        (bus)
    );

    always #50 clk10000hz = ~clk10000hz;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   frame_idx = 0;   // frames started since the last reset release

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Sample point: 1 time unit after the falling edge.
    task automatic tick();
        @(negedge clk10000hz);
        #1;
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0:  return 7'b1000000;
            4'd1:  return 7'b1111001;
            4'd2:  return 7'b0100100;
            4'd3:  return 7'b0110000;
            4'd4:  return 7'b0011001;
            4'd5:  return 7'b0010010;
            4'd6:  return 7'b0000010;
            4'd7:  return 7'b1111000;
            4'd8:  return 7'b0000000;
            4'd9:  return 7'b0010000;
            4'd10: return 7'b1000001;
            4'd11: return 7'b0100001;
            4'd12: return 7'b0111111;
            4'd13: return 7'b0000110;
            4'd14: return 7'b0000110;
            default: return 7'b1111111;
        endcase
    endfunction

    // Drive the status word for the upcoming frame and queue its four digits.
    task automatic push_frame(input logic [15:0] val);
        exp_t e;
        bit   blank;
        bus.data_bus = val;
        blank = bus.blink_en && (val[3:0] == 4'h0) && (((frame_idx / 25) % 2) == 1);
        for (int d = 3; d >= 0; d--) begin
            e.an  = 4'(~(4'b0001 << d));
            e.seg = bus.lamp_test ? 7'b0000000 :
                    (d == 2 && blank) ? 7'b1111111 : glyph(val[4*d +: 4]);
            e.dp  = ~bus.lamp_test;
            exp_q.push_back(e);
        end
    endtask

    // Follow one whole frame from its frame_tick; optionally change the bus
    // while digit 1 is lit. Leaves the bench on the next frame_tick cycle.
    task automatic check_frame(input string tag, input bit mid_en, input logic [15:0] mid_bus);
        exp_t e;
        int   bad;
        int   n;
        n = 0;
        while (bus.frame_tick !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (bus.frame_tick !== 1'b1) begin
            check({tag, " frame_tick timeout"}, 32'(bus.frame_tick), 32'd1);
            exp_q.delete();
            return;
        end
        check({tag, " start dead an_n"}, 32'(bus.an_n), 32'hF);
        for (int s = 0; s < 4; s++) begin
            e   = exp_q.pop_front();
            bad = 0;
            for (int c = 1; c < 25; c++) begin
                tick();
                if (mid_en && s == 2 && c == 5) bus.data_bus = mid_bus;
                if (c == 1) begin
                    check({tag, " an_n"},  32'(bus.an_n),  32'(e.an));
                    check({tag, " seg_n"}, 32'(bus.seg_n), 32'(e.seg));
                    check({tag, " dp_n"},  32'(bus.dp_n),  32'(e.dp));
                end else if (bus.an_n !== e.an || bus.seg_n !== e.seg || bus.dp_n !== e.dp) begin
                    bad++;
                end
                if (bus.frame_tick !== 1'b0) bad++;
            end
            check({tag, " digit hold"}, 32'(bad), 32'd0);
            tick();
            check({tag, " dead an_n"},  32'(bus.an_n),  32'hF);
            check({tag, " dead seg_n"}, 32'(bus.seg_n), 32'h7F);
            check({tag, " dead dp_n"},  32'(bus.dp_n),  32'd1);
            check({tag, " frame_tick"}, 32'(bus.frame_tick), (s == 3) ? 32'd1 : 32'd0);
        end
        frame_idx++;
    endtask

    initial begin
        bus.data_bus  = 16'h0000;
        bus.blink_en  = 1'b0;
        bus.lamp_test = 1'b0;

        // 1. Reset for three cycles, idle outputs throughout.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset an_n",       32'(bus.an_n),       32'hF);
            check("reset seg_n",      32'(bus.seg_n),      32'h7F);
            check("reset dp_n",       32'(bus.dp_n),       32'd1);
            check("reset frame_tick", 32'(bus.frame_tick), 32'd0);
        end
        reset = 1'b0;
        #1;
        frame_idx = 0;
        check("release frame_tick", 32'(bus.frame_tick), 32'd1);
        push_frame(16'h0000);
        check_frame("first frame", 1'b0, 16'h0000);

        // 2. Idle at floor 1, door open.
        push_frame(16'h01C1);
        check_frame("idle 01C1", 1'b0, 16'h0000);

        // 3. Bus change while digit 1 is lit is deferred to the next frame.
        push_frame(16'h01C1);
        check_frame("tear-free", 1'b1, 16'h1A20);
        push_frame(16'h1A20);
        check_frame("after change", 1'b0, 16'h0000);

        // 4. Floor blink with door closed, then none with door open.
        bus.blink_en = 1'b1;
        while (frame_idx < 55) begin
            push_frame(16'h1A20);
            check_frame("blink door0", 1'b0, 16'h0000);
        end
        while (frame_idx < 81) begin
            push_frame(16'h2201);
            check_frame("blink door1", 1'b0, 16'h0000);
        end
        bus.blink_en = 1'b0;

        // 5. Lamp test over blank glyphs.
        bus.lamp_test = 1'b1;
        push_frame(16'hFFFF);
        check_frame("lamp test", 1'b0, 16'h0000);
        push_frame(16'h1A20);
        check_frame("lamp test 1A20", 1'b0, 16'h0000);
        bus.lamp_test = 1'b0;

        // 6. Glyph sweep on digits 3 and 0 (covers 11, 13 and 15).
        for (int n = 0; n < 16; n++) begin
            push_frame({4'(n), 4'h5, 4'hC, 4'(n)});
            check_frame("glyph sweep", 1'b0, 16'h0000);
        end

        // 7. Reset asserted mid-digit-1.
        for (int i = 0; i < 60; i++) tick();
        check("pre-reset an_n", 32'(bus.an_n), 32'hD);
        reset = 1'b1;
        #1;
        check("mid reset an_n",  32'(bus.an_n),  32'hF);
        check("mid reset seg_n", 32'(bus.seg_n), 32'h7F);
        tick();
        check("mid reset edge an_n",       32'(bus.an_n),       32'hF);
        check("mid reset edge seg_n",      32'(bus.seg_n),      32'h7F);
        check("mid reset edge dp_n",       32'(bus.dp_n),       32'd1);
        check("mid reset edge frame_tick", 32'(bus.frame_tick), 32'd0);
        tick();
        check("mid reset hold frame_tick", 32'(bus.frame_tick), 32'd0);
        reset = 1'b0;
        #1;
        frame_idx = 0;
        check("restart frame_tick", 32'(bus.frame_tick), 32'd1);
        push_frame(16'h3B04);
        check_frame("restart", 1'b0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
